// File: rtl/task2_pkg.sv
// rtl/task2_pkg.sv - shared types and constants for the task2 bit-serial adder
//
// Purpose : holds the controller state encoding and the default operand width.
// Contents: DEFAULT_WIDTH - default operand/result width
//           state_t       - IDLE / RUN / DONE controller states
package task2_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/task2_full_adder.sv
// rtl/task2_full_adder.sv - single combinational full-adder slice
//
// Purpose : one bit of addition, reused every cycle by the serial adder.
// Ports   : a, b, cin - operand bits and carry in
//           s         - sum bit
//           cout      - carry out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/task2.sv
// rtl/task2.sv - bit-serial adder, one bit per clock, LSB first
//
// Purpose : adds two WIDTH-bit unsigned operands through a single full-adder
//           slice; the result appears on sum only once all bits are done.
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           load  - capture A and B into the operand registers (not in RUN)
//           start - begin an addition of the operand registers (not in RUN)
//           A, B  - unsigned operands
//           sum   - registered (A+B) mod 2^WIDTH
//           done  - high while sum holds a completed result
module task2
  import task2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic             idle_like;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign last      = (cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Result bit i lands at position cnt; the whole word is taken from acc_nxt
  // on the final bit so the MSB is included without an extra cycle.
  always_comb begin
    acc_nxt      = acc;
    acc_nxt[cnt] = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      done  <= 1'b0;
    end else if (idle_like) begin
      // A load on the start edge is what the new addition uses.
      if (load) begin
        opa <= A;
        opb <= B;
      end
      if (start) begin
        carry <= 1'b0;
        cnt   <= '0;
        done  <= 1'b0;
      end
    end else if (state == RUN) begin
      // Operands rotate rather than shift, so after WIDTH steps they are
      // back in place and a repeated start re-adds the same values.
      opa   <= {opa[0], opa[WIDTH-1:1]};
      opb   <= {opb[0], opb[WIDTH-1:1]};
      acc   <= acc_nxt;
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= acc_nxt;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_task2.sv
// tb/tb_task2.sv - self-checking bench for task2 against an arithmetic model
module tb_task2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] sum;
  logic         done;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: operation-level view (busy countdown, stored result).
  int m_busy;          // 0 = not running, else bits still to process
  int m_a, m_b, m_res, m_sum;
  bit m_done;

  always #5 clk = ~clk;

  task2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .start (start),
    .A     (A),
    .B     (B),
    .sum   (sum),
    .done  (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input bit s,
                            input int av, input int bv);
    if (!r) begin
      m_busy = 0; m_a = 0; m_b = 0; m_sum = 0; m_done = 0;
    end else if (m_busy == 0) begin
      if (l) begin m_a = av; m_b = bv; end
      if (s) begin
        m_res  = (m_a + m_b) % (1 << W);
        m_busy = W;
        m_done = 0;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        m_sum  = m_res;
        m_done = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit s,
                      input logic [W-1:0] av, input logic [W-1:0] bv);
    rst_n = r; load = l; start = s; A = av; B = bv;
    @(posedge clk);
    model_edge(r, l, s, int'(av), int'(bv));
    @(negedge clk);
    check("sum_model", int'(sum), m_sum);
    check("done_model", int'(done), int'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, W'($urandom), W'($urandom));
  endtask

  initial begin
    int lat;
    m_busy = 0; m_a = 0; m_b = 0; m_res = 0; m_sum = 0; m_done = 0;
    rst_n = 1'b0; load = 1'b0; start = 1'b0; A = '0; B = '0;

    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 4'hF, 4'hF);
    check("reset_sum", int'(sum), 0);
    check("reset_done", int'(done), 0);

    // 4 + 5: load then start, measure latency to done.
    step(1, 1, 0, 4, 5);
    step(1, 0, 1, 0, 0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      lat++;
      if (done) break;
    end
    check("lat_4p5", lat, W);
    check("sum_4p5", int'(sum), 9);

    // 3 + 7 with load and start on the same edge.
    step(1, 1, 1, 3, 7);
    idle(W);
    check("sum_3p7", int'(sum), 10);
    check("done_3p7", int'(done), 1);
    idle(2);
    check("hold_sum", int'(sum), 10);

    // 1 + 3 after a prior result: old sum visible, done low, during RUN.
    step(1, 1, 1, 1, 3);
    for (int i = 0; i < W - 1; i++) begin
      step(1, 0, 0, 0, 0);
      check("run_done_low", int'(done), 0);
      check("run_old_sum", int'(sum), 10);
    end
    step(1, 0, 0, 0, 0);
    check("sum_1p3", int'(sum), 4);

    // Load alone in DONE keeps done.
    step(1, 1, 0, 15, 1);
    check("load_keeps_done", int'(done), 1);

    // 15 + 1 wraps to 0.
    step(1, 0, 1, 0, 0);
    idle(W);
    check("sum_wrap", int'(sum), 0);
    check("done_wrap", int'(done), 1);

    // start and load mid-RUN are ignored.
    step(1, 1, 1, 2, 6);
    step(1, 1, 1, 9, 9);
    step(1, 1, 1, 9, 9);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("sum_ignore", int'(sum), 8);
    check("done_ignore", int'(done), 1);

    // Reset mid-RUN aborts; then a fresh operation.
    step(1, 1, 1, 5, 5);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("abort_sum", int'(sum), 0);
    check("abort_done", int'(done), 0);
    idle(W + 1);
    check("abort_no_done", int'(done), 0);
    step(1, 1, 1, 6, 7);
    idle(W);
    check("sum_after_reset", int'(sum), 13);

    // start held high: back-to-back operations on the same operands.
    for (int i = 0; i < 3 * (W + 1); i++) step(1, 0, 1, 0, 0);
    idle(W + 1);
    check("held_start_sum", int'(sum), 13);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
           W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
